three_input_gate_seq_v: RTL and testbench



---
 rtl/three_input_gate_seq_v.sv | 129 ++++++++++++
 tb/tb_three_input_gate_seq_v.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/three_input_gate_seq_v.sv
// Self-test sequencer that sweeps all codes and {a,b,c} vectors of the 3-input gate and checks the table.
// Optional first-mismatch capture is enabled with `define FIRST_FAIL_CAPTURE_EN.
module three_input_gate_seq_v #(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] GOLDEN        = 32'h69017F96
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_f,
    output logic        o_a,
    output logic        o_b,
    output logic        o_c,
    output logic [1:0]  o_code,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
`ifdef FIRST_FAIL_CAPTURE_EN
    output logic        o_fail_vld,
    output logic [1:0]  o_fail_code,
    output logic [2:0]  o_fail_idx,
`endif
    output logic [31:0] o_table
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam state_t     VEC_ENTRY   = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

    state_t     state;
    logic [3:0] settle_cnt;
    logic [1:0] code;
    logic [2:0] idx;
    logic       start_ok;

    // Abort wins over a simultaneous start in IDLE.
    assign start_ok = (state == IDLE) && i_start && !i_abort;

    assign o_code = code;
    assign {o_a, o_b, o_c} = idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            code       <= '0;
            idx        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_pass     <= 1'b0;
            o_table    <= '0;
        end else begin
            o_done <= 1'b0;
            if (state != IDLE && i_abort) begin
                state  <= IDLE;
                o_busy <= 1'b0;
                o_pass <= 1'b0;
                code   <= '0;
                idx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            o_table    <= '0;
                            o_pass     <= 1'b0;
                            code       <= '0;
                            idx        <= '0;
                            settle_cnt <= SETTLE_LOAD;
                            o_busy     <= 1'b1;
                            state      <= VEC_ENTRY;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt <= 4'd1) begin
                            state <= SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    SAMPLE: begin
                        o_table[{code, idx}] <= i_f;
                        if (code == 2'd3 && idx == 3'd7) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            code   <= '0;
                            idx    <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                            if (idx == 3'd7) begin
                                code <= code + 2'd1;
                            end
                            settle_cnt <= SETTLE_LOAD;
                            state      <= VEC_ENTRY;
                        end
                    end
                    DONE: begin
                        // The last bit landed on the previous edge, so the table is complete here.
                        o_done <= 1'b1;
                        o_pass <= (o_table == GOLDEN);
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fail_vld  <= 1'b0;
            o_fail_code <= '0;
            o_fail_idx  <= '0;
        end else if (start_ok) begin
            o_fail_vld  <= 1'b0;
            o_fail_code <= '0;
            o_fail_idx  <= '0;
        end else if (state == SAMPLE && !i_abort && !o_fail_vld
                     && (i_f != GOLDEN[{code, idx}])) begin
            o_fail_vld  <= 1'b1;
            o_fail_code <= code;
            o_fail_idx  <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_three_input_gate_seq_v.sv
// Scoreboard bench for three_input_gate_seq_v: three instances (settle 1, 0, 3) share start/abort/reset
// and each sees a behavioural gate model with an optional fault mask on its i_f.
module tb_three_input_gate_seq_v;

    typedef struct {
        logic [31:0] tbl;
        logic        pass;
        int          start_cyc;
        int          first_fail;
    } exp_t;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] fault_mask;

    logic        f     [N];
    logic        a     [N];
    logic        b     [N];
    logic        c     [N];
    logic [1:0]  code  [N];
    logic        busy  [N];
    logic        done  [N];
    logic        pass  [N];
    logic [31:0] tbl   [N];
`ifdef FIRST_FAIL_CAPTURE_EN
    logic        fvld  [N];
    logic [1:0]  fcode [N];
    logic [2:0]  fidx  [N];
`endif

    exp_t sb [N][$];
    int   busy_cnt [N];
    int   settle_of [N] = '{1, 0, 3};
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gate behaviour from its definition: XOR3, NAND3, NOR3, XNOR3 by code.
    function automatic logic gate_bit(input logic [1:0] k, input logic [2:0] v);
        int ones = $countones(v);
        case (k)
            2'd0:    return (ones % 2) == 1;
            2'd1:    return ones != 3;
            2'd2:    return ones == 0;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        assign f[g] = gate_bit(code[g], {a[g], b[g], c[g]}) ^ fault_mask[{code[g], a[g], b[g], c[g]}];

        three_input_gate_seq_v #(.SETTLE_CYCLES(S)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_start     (start),
            .i_abort     (abort),
            .i_f         (f[g]),
            .o_a         (a[g]),
            .o_b         (b[g]),
            .o_c         (c[g]),
            .o_code      (code[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .o_pass      (pass[g]),
`ifdef FIRST_FAIL_CAPTURE_EN
            .o_fail_vld  (fvld[g]),
            .o_fail_code (fcode[g]),
            .o_fail_idx  (fidx[g]),
`endif
            .o_table     (tbl[g])
        );
    end

    task automatic check_output(input string name, input int inst, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, inst, act, exp, cyc);
        end
    endtask

    // Queue the expected sweep result for every instance, then pulse start for one edge.
    task automatic apply_stimulus(input logic [31:0] mask);
        exp_t e;
        fault_mask = mask;
        for (int i = 0; i < 32; i++) begin
            e.tbl[i] = gate_bit(2'(i >> 3), 3'(i)) ^ mask[i];
        end
        e.pass       = (mask == 32'd0);
        e.start_cyc  = cyc + 1;
        e.first_fail = -1;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) e.first_fail = i;
        end
        for (int g = 0; g < N; g++) sb[g].push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_all(input int budget);
        int pending = 1;
        for (int i = 0; i < budget && pending != 0; i++) begin
            @(posedge clk);
            #1;
            pending = 0;
            for (int g = 0; g < N; g++) pending += sb[g].size();
        end
        check_output("run_timeout", 0, 32'(pending), 32'd0);
    endtask

    task automatic flush_expectations();
        for (int g = 0; g < N; g++) begin
            sb[g].delete();
            busy_cnt[g] = 0;
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int g = 0; g < N; g++) begin
            check_output({name, "_stim"}, g, {27'd0, code[g], a[g], b[g], c[g]}, 32'd0);
            check_output({name, "_flags"}, g, {29'd0, busy[g], done[g], pass[g]}, 32'd0);
            check_output({name, "_table"}, g, tbl[g], 32'd0);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) busy_cnt[g] = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fault_mask = 32'd0;

        fork
            begin : stimulus
                logic [31:0] m;
                #12;
                check_all_zero("reset");
                @(posedge clk);
                #1 rst_n = 1'b1;
                idle_cycles(2);

                apply_stimulus(32'd0);
                wait_all(400);

                // XNOR decode replaced by XOR: code 3 byte becomes 0x96.
                apply_stimulus(32'hFF000000);
                wait_all(400);

                for (int r = 0; r < 6; r++) begin
                    case ($urandom_range(2))
                        0:       m = 32'd0;
                        1:       m = 32'd1 << $urandom_range(31);
                        default: m = $urandom;
                    endcase
                    idle_cycles($urandom_range(3));
                    apply_stimulus(m);
                    wait_all(400);
                end

                // A second start while busy must not restart or duplicate the sweep.
                apply_stimulus(32'd0);
                idle_cycles(8);
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                wait_all(400);
                idle_cycles(20);

                // Abort at cycle 20 of the sweep.
                apply_stimulus(32'd0);
                idle_cycles(18);
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                flush_expectations();
                for (int g = 0; g < N; g++) begin
                    check_output("abort_busy", g, 32'(busy[g]), 32'd0);
                    check_output("abort_pass", g, 32'(pass[g]), 32'd0);
                end
                idle_cycles(160);
                apply_stimulus(32'd0);
                wait_all(400);

                // Abort together with start in IDLE: start must be ignored.
                abort = 1'b1;
                start = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                start = 1'b0;
                for (int g = 0; g < N; g++) check_output("abort_start_busy", g, 32'(busy[g]), 32'd0);
                idle_cycles(160);

                // Asynchronous reset at cycle 30 of the sweep.
                apply_stimulus(32'h00000F00);
                idle_cycles(28);
                rst_n = 1'b0;
                #1;
                check_all_zero("midreset");
                flush_expectations();
                #1 rst_n = 1'b1;
                idle_cycles(2);
                apply_stimulus(32'd0);
                wait_all(400);
                idle_cycles(5);
            end
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    for (int g = 0; g < N; g++) begin
                        if (busy[g]) busy_cnt[g]++;
                        if (done[g]) begin
                            check_output("done_expected", g, 32'(sb[g].size() > 0), 32'd1);
                            if (sb[g].size() > 0) begin
                                e = sb[g].pop_front();
                                check_output("table", g, tbl[g], e.tbl);
                                check_output("pass", g, 32'(pass[g]), 32'(e.pass));
                                check_output("latency", g, 32'(cyc - e.start_cyc),
                                             32'(32 * (settle_of[g] + 1) + 1));
                                check_output("busy_len", g, 32'(busy_cnt[g]),
                                             32'(32 * (settle_of[g] + 1)));
`ifdef FIRST_FAIL_CAPTURE_EN
                                check_output("fail_vld", g, 32'(fvld[g]), 32'(e.first_fail >= 0));
                                if (e.first_fail >= 0) begin
                                    check_output("fail_pos", g, {27'd0, fcode[g], fidx[g]},
                                                 32'(e.first_fail));
                                end
`endif
                            end
                            busy_cnt[g] = 0;
                        end
                    end
                end
            end
        join_any

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
